nbit_packer: RTL and testbench

Parametrised narrow-to-wide packer; next generation of the team's 8b->32b converter. Gathers RATIO input lanes of IN_W bits into one IN_W*RATIO word. Adds over the fixed 8->32 block:
- selectable lane order
- ready/valid backpressure on both sides
- partial-word flush with a lane-keep mask
Sits in the clk_4f domain between the byte-serial path and the wide parallel path.

---
 rtl/nbit_pkg.sv | 20 ++
 rtl/nbit_out_reg.sv | 58 +++++
 rtl/nbit_packer.sv | 128 ++++++++++++
 tb/tb_nbit_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nbit_pkg.sv
// Shared definitions for the narrow-to-wide packer: default geometry and lane placement.
package nbit_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int RATIO_DEF = 4;
    localparam int OUT_W     = IN_W_DEF * RATIO_DEF;
    localparam int CNT_W     = $clog2(RATIO_DEF);

    // Bit offset of lane idx (arrival order) inside the packed word.
    function automatic int lane_pos(input int idx, input int in_w, input int ratio, input int msb_first);
        int pos;
        if (msb_first != 0) begin
            pos = (ratio - 1 - idx) * in_w;
        end else begin
            pos = idx * in_w;
        end
        return pos;
    endfunction

endpackage

// File: rtl/nbit_out_reg.sv
// Output holding register: captures a packed word on load, clears to all-zero once taken.
module nbit_out_reg
    import nbit_pkg::*;
#(
    parameter int DATA_W = OUT_W,
    parameter int KEEP_W = RATIO_DEF
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] word_in,
    input  logic [KEEP_W-1:0] keep_in,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic [KEEP_W-1:0] keep_out,
    output logic              valid_out
);

    logic [DATA_W-1:0] data_d, data_q;
    logic [KEEP_W-1:0] keep_d, keep_q;
    logic              valid_d, valid_q;

    // Next output word: a load always wins over a take, so back-to-back words stay valid.
    always_comb begin
        data_d  = data_q;
        keep_d  = keep_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = word_in;
            keep_d  = keep_in;
            valid_d = 1'b1;
        end else if (valid_q && ready_in) begin
            data_d  = {DATA_W{1'b0}};
            keep_d  = {KEEP_W{1'b0}};
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output state register.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            data_q  <= {DATA_W{1'b0}};
            keep_q  <= {KEEP_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/nbit_packer.sv
// Narrow-to-wide packer: gathers RATIO lanes of IN_W bits with backpressure and partial flush.
module nbit_packer
    import nbit_pkg::*;
#(
    parameter int IN_W          = IN_W_DEF,
    parameter int RATIO         = RATIO_DEF,
    parameter int MSB_FIRST     = 1,
    parameter int FLUSH_PARTIAL = 1
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic                  valid_out,
    output logic [RATIO-1:0]      keep_out,
    input  logic                  ready_in
);

    localparam int W_OUT = IN_W * RATIO;
    localparam int W_CNT = $clog2(RATIO);

    logic [W_OUT-1:0] acc_d, acc_q;
    logic [RATIO-1:0] keep_d, keep_q;
    logic [W_CNT-1:0] cnt_d, cnt_q;
    logic             pending_d, pending_q;

    logic             accept_s, free_s, load_s;
    logic [W_OUT-1:0] lane_word_s, ld_word_s;
    logic [RATIO-1:0] lane_keep_s, ld_keep_s;

    assign ready_out = !pending_q;
    assign accept_s  = valid_in & ready_out;
    assign free_s    = !valid_out | ready_in;

    // Accumulator update, completion/flush decisions and the load strobe to the output register.
    always_comb begin
        acc_d       = acc_q;
        keep_d      = keep_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        load_s      = 1'b0;
        ld_word_s   = acc_q;
        ld_keep_s   = keep_q;
        lane_word_s = acc_q | (W_OUT'(data_in) << lane_pos(int'(cnt_q), IN_W, RATIO, MSB_FIRST));
        lane_keep_s = keep_q | (RATIO'(1) << cnt_q);
        if (pending_q) begin
            if (free_s) begin
                load_s    = 1'b1;
                acc_d     = {W_OUT{1'b0}};
                keep_d    = {RATIO{1'b0}};
                cnt_d     = {W_CNT{1'b0}};
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (accept_s) begin
            if (cnt_q == W_CNT'(RATIO - 1)) begin
                if (free_s) begin
                    load_s    = 1'b1;
                    ld_word_s = lane_word_s;
                    ld_keep_s = lane_keep_s;
                    acc_d     = {W_OUT{1'b0}};
                    keep_d    = {RATIO{1'b0}};
                    cnt_d     = {W_CNT{1'b0}};
                end else begin
                    acc_d     = lane_word_s;
                    keep_d    = lane_keep_s;
                    pending_d = 1'b1;
                end
            end else begin
                acc_d  = lane_word_s;
                keep_d = lane_keep_s;
                cnt_d  = cnt_q + W_CNT'(1);
            end
        end else if (!valid_in && (cnt_q != {W_CNT{1'b0}})) begin
            // Stream ended mid-word: either emit what we have or drop it.
            if (FLUSH_PARTIAL != 0) begin
                if (free_s) begin
                    load_s = 1'b1;
                    acc_d  = {W_OUT{1'b0}};
                    keep_d = {RATIO{1'b0}};
                    cnt_d  = {W_CNT{1'b0}};
                end else begin
                    pending_d = 1'b1;
                end
            end else begin
                acc_d  = {W_OUT{1'b0}};
                keep_d = {RATIO{1'b0}};
                cnt_d  = {W_CNT{1'b0}};
            end
        end else begin
            pending_d = pending_q;
        end
    end

    // Accumulator, lane counter and pending-word state.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            acc_q     <= {W_OUT{1'b0}};
            keep_q    <= {RATIO{1'b0}};
            cnt_q     <= {W_CNT{1'b0}};
            pending_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            keep_q    <= keep_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    nbit_out_reg #(
        .DATA_W(W_OUT),
        .KEEP_W(RATIO)
    ) u_out_reg (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .load     (load_s),
        .word_in  (ld_word_s),
        .keep_in  (ld_keep_s),
        .ready_in (ready_in),
        .data_out (data_out),
        .keep_out (keep_out),
        .valid_out(valid_out)
    );

endmodule

// File: tb/tb_nbit_packer.sv
// Directed bench for nbit_packer: four parameterisations driven from one scenario sequence.
module tb_nbit_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready_in = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [3:0]  din_d = 4'h0;
    logic        va = 1'b0, vb = 1'b0, vc = 1'b0, vd = 1'b0;

    logic        rdy_a, rdy_b, rdy_c, rdy_d;
    logic [31:0] dout_a, dout_b, dout_c, dout_d;
    logic        vo_a, vo_b, vo_c, vo_d;
    logic [3:0]  keep_a, keep_b, keep_c;
    logic [7:0]  keep_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nbit_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1), .FLUSH_PARTIAL(1)) dut_a (
        .clk_4f(clk), .reset(reset), .data_in(din), .valid_in(va), .ready_out(rdy_a),
        .data_out(dout_a), .valid_out(vo_a), .keep_out(keep_a), .ready_in(ready_in));

    nbit_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0), .FLUSH_PARTIAL(1)) dut_b (
        .clk_4f(clk), .reset(reset), .data_in(din), .valid_in(vb), .ready_out(rdy_b),
        .data_out(dout_b), .valid_out(vo_b), .keep_out(keep_b), .ready_in(ready_in));

    nbit_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1), .FLUSH_PARTIAL(0)) dut_c (
        .clk_4f(clk), .reset(reset), .data_in(din), .valid_in(vc), .ready_out(rdy_c),
        .data_out(dout_c), .valid_out(vo_c), .keep_out(keep_c), .ready_in(ready_in));

    nbit_packer #(.IN_W(4), .RATIO(8), .MSB_FIRST(1), .FLUSH_PARTIAL(1)) dut_d (
        .clk_4f(clk), .reset(reset), .data_in(din_d), .valid_in(vd), .ready_out(rdy_d),
        .data_out(dout_d), .valid_out(vo_d), .keep_out(keep_d), .ready_in(ready_in));

    task automatic push_a(input logic [7:0] b);
        @(negedge clk);
        va = 1'b1;
        din = b;
    endtask

    task automatic test_reset();
        n_checks++;
        if (rdy_a !== 1'b1 || vo_a !== 1'b0 || dout_a !== 32'h0 || keep_a !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_a: rdy=%b vo=%b data=%h keep=%h, expected 1 0 0 0", rdy_a, vo_a, dout_a, keep_a);
        end
        n_checks++;
        if (rdy_d !== 1'b1 || vo_d !== 1'b0 || dout_d !== 32'h0 || keep_d !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_d: rdy=%b vo=%b data=%h keep=%h, expected 1 0 0 0", rdy_d, vo_d, dout_d, keep_d);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_msb_first();
        ready_in = 1'b1;
        push_a(8'hAA); push_a(8'hBB); push_a(8'hCC); push_a(8'hDD);
        @(negedge clk);
        va = 1'b0;
        n_checks++;
        if (dout_a !== 32'hAABBCCDD || keep_a !== 4'hF || vo_a !== 1'b1) begin
            n_fail++;
            $display("FAIL msb_word: data=%h keep=%h vo=%b, expected aabbccdd f 1", dout_a, keep_a, vo_a);
        end
        @(negedge clk);
        n_checks++;
        if (dout_a !== 32'h0 || keep_a !== 4'h0 || vo_a !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_idle: data=%h keep=%h vo=%b, expected 0 0 0", dout_a, keep_a, vo_a);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vb = 1'b1;
            din = bytes[i];
        end
        @(negedge clk);
        vb = 1'b0;
        n_checks++;
        if (dout_b !== 32'h44332211 || keep_b !== 4'hF || vo_b !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_word: data=%h keep=%h vo=%b, expected 44332211 f 1", dout_b, keep_b, vo_b);
        end
    endtask

    task automatic test_backpressure();
        ready_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push_a(8'(i));
        end
        @(negedge clk);
        va = 1'b0;
        n_checks++;
        if (rdy_a !== 1'b0 || vo_a !== 1'b1 || dout_a !== 32'h01020304) begin
            n_fail++;
            $display("FAIL bp_hold: rdy=%b vo=%b data=%h, expected 0 1 01020304", rdy_a, vo_a, dout_a);
        end
        @(negedge clk);
        n_checks++;
        if (rdy_a !== 1'b0 || vo_a !== 1'b1 || dout_a !== 32'h01020304) begin
            n_fail++;
            $display("FAIL bp_hold2: rdy=%b vo=%b data=%h, expected 0 1 01020304", rdy_a, vo_a, dout_a);
        end
        ready_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rdy_a !== 1'b1 || vo_a !== 1'b1 || dout_a !== 32'h05060708 || keep_a !== 4'hF) begin
            n_fail++;
            $display("FAIL bp_second: rdy=%b vo=%b data=%h keep=%h, expected 1 1 05060708 f", rdy_a, vo_a, dout_a, keep_a);
        end
        @(negedge clk);
        n_checks++;
        if (vo_a !== 1'b0 || dout_a !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_drain: vo=%b data=%h, expected 0 0", vo_a, dout_a);
        end
    endtask

    task automatic test_flush();
        ready_in = 1'b1;
        push_a(8'hE1); push_a(8'hE2);
        @(negedge clk);
        va = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dout_a !== 32'hE1E20000 || keep_a !== 4'b0011 || vo_a !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_word: data=%h keep=%b vo=%b, expected e1e20000 0011 1", dout_a, keep_a, vo_a);
        end
        @(negedge clk);
        n_checks++;
        if (vo_a !== 1'b0 || keep_a !== 4'h0) begin
            n_fail++;
            $display("FAIL flush_once: vo=%b keep=%h, expected 0 0", vo_a, keep_a);
        end
    endtask

    task automatic test_no_flush();
        logic seen;
        logic [7:0] bytes [6];
        bytes[0] = 8'hE1; bytes[1] = 8'hE2;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vc = 1'b1;
            din = bytes[i];
        end
        @(negedge clk);
        vc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | vo_c;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL noflush_quiet: valid_out seen=%b, expected 0", seen);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vc = 1'b1;
            din = 8'(i);
        end
        @(negedge clk);
        vc = 1'b0;
        n_checks++;
        if (dout_c !== 32'h01020304 || keep_c !== 4'hF || vo_c !== 1'b1) begin
            n_fail++;
            $display("FAIL noflush_next: data=%h keep=%h vo=%b, expected 01020304 f 1", dout_c, keep_c, vo_c);
        end
    endtask

    task automatic test_async_reset();
        ready_in = 1'b1;
        push_a(8'h10); push_a(8'h20); push_a(8'h30);
        @(negedge clk);
        va = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rdy_a !== 1'b1 || vo_a !== 1'b0 || dout_a !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_midword: rdy=%b vo=%b data=%h, expected 1 0 0", rdy_a, vo_a, dout_a);
        end
        #2;
        reset = 1'b0;
        ready_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push_a(8'(8'h40 + i));
        end
        @(negedge clk);
        va = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rdy_a !== 1'b1 || vo_a !== 1'b0 || dout_a !== 32'h0 || keep_a !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_pending: rdy=%b vo=%b data=%h keep=%h, expected 1 0 0 0", rdy_a, vo_a, dout_a, keep_a);
        end
        @(negedge clk);
        reset = 1'b0;
        ready_in = 1'b1;
        push_a(8'h9A); push_a(8'h9B); push_a(8'h9C); push_a(8'h9D);
        @(negedge clk);
        va = 1'b0;
        n_checks++;
        if (dout_a !== 32'h9A9B9C9D || keep_a !== 4'hF || vo_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_recover: data=%h keep=%h vo=%b, expected 9a9b9c9d f 1", dout_a, keep_a, vo_a);
        end
    endtask

    task automatic test_wide_ratio();
        ready_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            vd = 1'b1;
            din_d = 4'(i);
        end
        @(negedge clk);
        vd = 1'b0;
        n_checks++;
        if (dout_d !== 32'h12345678 || keep_d !== 8'hFF || vo_d !== 1'b1) begin
            n_fail++;
            $display("FAIL nibble_word: data=%h keep=%h vo=%b, expected 12345678 ff 1", dout_d, keep_d, vo_d);
        end
        @(negedge clk);
        n_checks++;
        if (vo_d !== 1'b0 || dout_d !== 32'h0) begin
            n_fail++;
            $display("FAIL nibble_idle: vo=%b data=%h, expected 0 0", vo_d, dout_d);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_flush();
        test_no_flush();
        test_async_reset();
        test_wide_ratio();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
